// File: rtl/mtp_rd_arbiter.sv
// mtp_rd_arbiter: shares the MTP read port between init (req 0, priority) and cmd (req 1).
// Optional MTP_RD_RETRY_EN: re-issue a read once after its first ack timeout.
module mtp_rd_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 8,
  parameter int TMO_W   = 4
) (
  input  logic              init_clk,
  input  logic              rst_n,
  input  logic              req_init_i,
  input  logic [ADDR_W-1:0] addr_init_i,
  input  logic              req_cmd_i,
  input  logic [ADDR_W-1:0] addr_cmd_i,
  input  logic              mtp_ack_i,
  input  logic [DATA_W-1:0] mtp_data_i,
  output logic              mtp_rd_en_o,
  output logic [ADDR_W-1:0] mtp_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_err_o,
  output logic              done_init_o,
  output logic              done_cmd_o,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | no read in flight; arbitrate init over cmd
  // ISSUE | read strobe high for this cycle, ack window restarts
  // WAIT  | waiting for mtp_ack or the timeout count
  // DONE  | one-cycle done to the granted requester
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_en_q, rd_en_d;
  logic              done_init_q, done_init_d;
  logic              done_cmd_q, done_cmd_d;
  logic              busy_q, busy_d;
`ifdef MTP_RD_RETRY_EN
  logic              retry_q, retry_d;
`endif

  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      addr_q      <= '0;
      tmo_cnt_q   <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      done_init_q <= 1'b0;
      done_cmd_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MTP_RD_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      rd_en_q     <= rd_en_d;
      done_init_q <= done_init_d;
      done_cmd_q  <= done_cmd_d;
      busy_q      <= busy_d;
`ifdef MTP_RD_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    tmo_cnt_d = tmo_cnt_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
`ifdef MTP_RD_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef MTP_RD_RETRY_EN
        retry_d = 1'b0;
`endif
        if (req_init_i) begin
          grant_d = 1'b0;
          addr_d  = addr_init_i;
          state_d = ST_ISSUE;
        end else if (req_cmd_i) begin
          grant_d = 1'b1;
          addr_d  = addr_cmd_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // ack takes precedence over a timeout in the same cycle
        if (mtp_ack_i) begin
          rd_data_d = mtp_data_i;
          rd_err_d  = 1'b0;
          state_d   = ST_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
`ifdef MTP_RD_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
            state_d   = ST_DONE;
          end
`else
          rd_data_d = '0;
          rd_err_d  = 1'b1;
          state_d   = ST_DONE;
`endif
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // outputs are registered, so they are decoded from the next state
    rd_en_d     = (state_d == ST_ISSUE);
    done_init_d = (state_d == ST_DONE) && !grant_d;
    done_cmd_d  = (state_d == ST_DONE) && grant_d;
    busy_d      = (state_d != ST_IDLE);
  end

  assign mtp_rd_en_o = rd_en_q;
  assign mtp_addr_o  = addr_q;
  assign rd_data_o   = rd_data_q;
  assign rd_err_o    = rd_err_q;
  assign done_init_o = done_init_q;
  assign done_cmd_o  = done_cmd_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mtp_rd_arbiter.sv
// tb_mtp_rd_arbiter: directed and randomized reads checked against a transaction-level model.
// Expectations follow MTP_RD_RETRY_EN when it is defined for the build.
module tb_mtp_rd_arbiter;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int TMO_CYC = 8;
  localparam int TMO_W   = 4;
`ifdef MTP_RD_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic              init_clk;
  logic              rst_n;
  logic              req_init_i;
  logic [ADDR_W-1:0] addr_init_i;
  logic              req_cmd_i;
  logic [ADDR_W-1:0] addr_cmd_i;
  logic              mtp_ack_i;
  logic [DATA_W-1:0] mtp_data_i;
  logic              mtp_rd_en_o;
  logic [ADDR_W-1:0] mtp_addr_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_err_o;
  logic              done_init_o;
  logic              done_cmd_o;
  logic              busy_o;

  int n_cmp = 0;
  int n_err = 0;

  mtp_rd_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TMO_CYC(TMO_CYC),
    .TMO_W  (TMO_W)
  ) dut (
    .init_clk   (init_clk),
    .rst_n      (rst_n),
    .req_init_i (req_init_i),
    .addr_init_i(addr_init_i),
    .req_cmd_i  (req_cmd_i),
    .addr_cmd_i (addr_cmd_i),
    .mtp_ack_i  (mtp_ack_i),
    .mtp_data_i (mtp_data_i),
    .mtp_rd_en_o(mtp_rd_en_o),
    .mtp_addr_o (mtp_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_err_o   (rd_err_o),
    .done_init_o(done_init_o),
    .done_cmd_o (done_cmd_o),
    .busy_o     (busy_o)
  );

  initial init_clk = 1'b0;
  always #5 init_clk = ~init_clk;

  task automatic tick();
    @(posedge init_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One granted read. a1/a2: WAIT cycle (1..TMO_CYC) of the ack in the first/second
  // strobe window, 0 = no ack. Cycle n=1 is the edge that samples the request.
  task automatic run_txn(input bit ri, input bit rc, input logic [ADDR_W-1:0] ai,
                         input logic [ADDR_W-1:0] ac, input logic [DATA_W-1:0] dat,
                         input int a1, input int a2, input bit drop_early);
    int n, since, strobes, exp_strobes, exp_done, exp_s2, w1, w2;
    bit win_cmd, exp_err, got_done, stray;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    win_cmd  = !ri;
    exp_addr = ri ? ai : ac;
    w1 = (a1 != 0) ? a1 : TMO_CYC;
    if (a1 != 0 || !RETRY) begin
      exp_strobes = 1;
      exp_s2      = -1;
      exp_done    = 1 + w1 + 1;
      exp_err     = (a1 == 0);
    end else begin
      w2          = (a2 != 0) ? a2 : TMO_CYC;
      exp_strobes = 2;
      exp_s2      = 1 + w1 + 1;
      exp_done    = exp_s2 + w2 + 1;
      exp_err     = (a2 == 0);
    end
    exp_data = exp_err ? '0 : dat;
    stray    = 1'($urandom_range(0, 1));

    req_init_i  = ri;
    req_cmd_i   = rc;
    addr_init_i = ai;
    addr_cmd_i  = ac;
    mtp_ack_i   = 1'b0;
    n = 0; since = 0; strobes = 0; got_done = 1'b0;
    while (!got_done && n < 60) begin
      tick();
      n++;
      since++;
      if (mtp_rd_en_o) begin
        strobes++;
        since = 0;
        chk("strobe_cycle", n, (strobes == 1) ? 1 : exp_s2);
        chk("strobe_addr", mtp_addr_o, exp_addr);
        if (drop_early) begin
          if (win_cmd) req_cmd_i = 1'b0;
          else         req_init_i = 1'b0;
        end
      end
      if (done_init_o || done_cmd_o) begin
        got_done = 1'b1;
        chk("done_cycle", n, exp_done);
        chk("done_init", done_init_o, !win_cmd);
        chk("done_cmd", done_cmd_o, win_cmd);
        chk("rd_data", rd_data_o, exp_data);
        chk("rd_err", rd_err_o, exp_err);
        chk("strobe_count", strobes, exp_strobes);
        chk("addr_in_done", mtp_addr_o, exp_addr);
        chk("busy_in_done", busy_o, 1);
        mtp_ack_i = 1'b0;
        if (win_cmd) req_cmd_i = 1'b0;
        else         req_init_i = 1'b0;
      end else begin
        mtp_ack_i  = 1'b0;
        mtp_data_i = DATA_W'($urandom);
        if (strobes > 0) begin
          if (since == 0) begin
            mtp_ack_i  = stray;
            mtp_data_i = ~dat;
          end else if (since == ((strobes == 1) ? a1 : a2)) begin
            mtp_ack_i  = 1'b1;
            mtp_data_i = dat;
          end
        end
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    tick();
    chk("idle_busy", busy_o, 0);
    chk("idle_dones", {done_init_o, done_cmd_o}, 2'b00);
    chk("idle_addr_hold", mtp_addr_o, exp_addr);
    chk("idle_data_hold", {rd_err_o, rd_data_o}, {exp_err, exp_data});
  endtask

  initial begin
    bit ri, rc, de;
    logic [ADDR_W-1:0] ai, ac;
    logic [DATA_W-1:0] d;
    int a1, a2;

    rst_n       = 1'b0;
    req_init_i  = 1'b0;
    req_cmd_i   = 1'b0;
    addr_init_i = '0;
    addr_cmd_i  = '0;
    mtp_ack_i   = 1'b0;
    mtp_data_i  = '0;
    #2;
    chk("rst_rd_en", mtp_rd_en_o, 0);
    chk("rst_addr", mtp_addr_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_err", rd_err_o, 0);
    chk("rst_dones", {done_init_o, done_cmd_o}, 2'b00);
    chk("rst_busy", busy_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_o, 0);

    // single init read, ack in the first WAIT cycle
    run_txn(1'b1, 1'b0, 6'h05, 6'h00, 16'h3014, 1, 0, 1'b0);

    // contention: init first, then cmd once req_init has dropped
    run_txn(1'b1, 1'b1, 6'h07, 6'h20, 16'h1234, 2, 0, 1'b0);
    run_txn(1'b0, 1'b1, 6'h07, 6'h20, 16'hBEEF, 1, 0, 1'b0);

    // cmd timeout with no ack at all
    run_txn(1'b0, 1'b1, 6'h00, 6'h11, 16'h7777, 0, 0, 1'b0);

    // no ack in first window, ack in the second
    run_txn(1'b0, 1'b1, 6'h00, 6'h12, 16'hA5A5, 0, 3, 1'b0);

    // ack in the final WAIT cycle collides with the timeout
    run_txn(1'b1, 1'b0, 6'h3F, 6'h00, 16'hC0DE, TMO_CYC, 0, 1'b1);

    // stray ack in IDLE
    mtp_ack_i  = 1'b1;
    mtp_data_i = 16'hFFFF;
    tick();
    mtp_ack_i = 1'b0;
    tick();
    chk("stray_dones", {done_init_o, done_cmd_o, mtp_rd_en_o}, 3'b000);
    chk("stray_busy", busy_o, 0);
    chk("stray_data_hold", rd_data_o, 16'hC0DE);

    // reset in the middle of WAIT
    req_cmd_i  = 1'b1;
    addr_cmd_i = 6'h2A;
    tick();
    chk("rw_strobe", mtp_rd_en_o, 1);
    tick();
    tick();
    tick();
    chk("rw_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_rd_en", mtp_rd_en_o, 0);
    chk("rw_addr", mtp_addr_o, 0);
    chk("rw_data_err", {rd_err_o, rd_data_o}, 17'h0);
    chk("rw_dones", {done_init_o, done_cmd_o}, 2'b00);
    chk("rw_busy", busy_o, 0);
    req_cmd_i = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < TMO_CYC + 3; k++) begin
      tick();
      chk("rw_no_done", {done_init_o, done_cmd_o, busy_o}, 3'b000);
    end
    run_txn(1'b0, 1'b1, 6'h00, 6'h2B, 16'h4242, 2, 0, 1'b0);

    // randomized reads
    for (int i = 0; i < 25; i++) begin
      ri = 1'($urandom_range(0, 1));
      rc = ri ? 1'($urandom_range(0, 1)) : 1'b1;
      ai = ADDR_W'($urandom);
      ac = ADDR_W'($urandom);
      d  = DATA_W'($urandom);
      a1 = $urandom_range(0, TMO_CYC);
      a2 = $urandom_range(0, TMO_CYC);
      de = 1'($urandom_range(0, 1));
      run_txn(ri, rc, ai, ac, d, a1, a2, de);
      if (ri && rc) begin
        d  = DATA_W'($urandom);
        a1 = $urandom_range(0, TMO_CYC);
        a2 = $urandom_range(0, TMO_CYC);
        run_txn(1'b0, 1'b1, ai, ac, d, a1, a2, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
